// File: rtl/line_window_buffer.sv
// line_window_buffer
//   Streaming window generator. Raster-order pixels arrive on a valid/ready
//   handshake. P_WINDOW-1 circular line stores hold the previous lines, and a
//   P_WINDOW x P_WINDOW window is emitted per qualifying accepted pixel.
//   The output register has one cycle of latency and supports backpressure.
//
//   Optional build macro: LINE_WINDOW_BUFFER_ZERO_PAD_EN
//     When defined, every accepted pixel yields a window, and taps lying
//     above the top edge or left of the left edge read as 0.
//     When undefined, only windows lying fully inside the frame are emitted.
module line_window_buffer #(
  parameter int P_COLUMNS     = 640,
  parameter int P_ROWS        = 480,
  parameter int P_WINDOW      = 3,
  parameter int P_PIXEL_DEPTH = 8
) (
  input  logic                                         I_CLK,
  input  logic                                         I_RESET_N,
  input  logic [P_PIXEL_DEPTH-1:0]                     I_PIXEL,
  input  logic                                         I_VALID,
  input  logic                                         I_SOF,
  output logic                                         O_READY,
  output logic [P_WINDOW*P_WINDOW*P_PIXEL_DEPTH-1:0]   O_WINDOW,
  output logic [$clog2(P_ROWS)-1:0]                    O_ROW,
  output logic [$clog2(P_COLUMNS)-1:0]                 O_COL,
  output logic                                         O_EOF,
  output logic                                         O_VALID,
  input  logic                                         I_READY
);

  localparam int L_COL_W  = $clog2(P_COLUMNS);
  localparam int L_ROW_W  = $clog2(P_ROWS);
  localparam int L_LINES  = P_WINDOW - 1;
  localparam int L_PTR_W  = (L_LINES > 1) ? $clog2(L_LINES) : 1;
  localparam int L_WIN_W  = P_WINDOW * P_WINDOW * P_PIXEL_DEPTH;

  logic [L_COL_W-1:0] col_q;
  logic [L_COL_W-1:0] col_eff;
  logic [L_COL_W-1:0] col_nxt;
  logic [L_ROW_W-1:0] row_q;
  logic [L_ROW_W-1:0] row_eff;
  logic [L_ROW_W-1:0] row_nxt;
  logic [L_PTR_W-1:0] wptr_q;
  logic [L_PTR_W-1:0] wptr_nxt;

  logic accept;
  logic qualified;
  logic eof_nxt;

  // Line stores: not reset, contents are always overwritten before use.
  logic [P_PIXEL_DEPTH-1:0] line_mem [L_LINES][P_COLUMNS];

  // Column taps gathered this cycle (oldest line first, incoming pixel last).
  logic [P_PIXEL_DEPTH-1:0] new_col [P_WINDOW];

  // Last P_WINDOW-1 columns of the sliding window; the oldest column is
  // dropped on each shift, so only these need to be stored.
  logic [P_PIXEL_DEPTH-1:0] hist_q [P_WINDOW][L_LINES];
  logic [P_PIXEL_DEPTH-1:0] hist_d [P_WINDOW][L_LINES];

  // Window as it will look after this accept.
  logic [P_PIXEL_DEPTH-1:0] win_nxt [P_WINDOW][P_WINDOW];
  logic [L_WIN_W-1:0]       window_flat;

  assign O_READY = I_RESET_N && (I_READY || !O_VALID);
  assign accept  = I_VALID && O_READY;

  // A start-of-frame pixel is placed at (0,0) whatever the counters say.
  assign col_eff = I_SOF ? '0 : col_q;
  assign row_eff = I_SOF ? '0 : row_q;

  assign eof_nxt = (row_eff == L_ROW_W'(P_ROWS - 1)) &&
                   (col_eff == L_COL_W'(P_COLUMNS - 1));

`ifdef LINE_WINDOW_BUFFER_ZERO_PAD_EN
  assign qualified = 1'b1;
`else
  assign qualified = (row_eff >= L_ROW_W'(P_WINDOW - 1)) &&
                     (col_eff >= L_COL_W'(P_WINDOW - 1));
`endif

  // Raster position and line-write pointer advance for the next pixel.
  always_comb begin
    col_nxt  = col_eff + 1'b1;
    row_nxt  = row_eff;
    wptr_nxt = wptr_q;
    if (col_eff == L_COL_W'(P_COLUMNS - 1)) begin
      col_nxt  = '0;
      row_nxt  = (row_eff == L_ROW_W'(P_ROWS - 1)) ? '0 : row_eff + 1'b1;
      wptr_nxt = (wptr_q == L_PTR_W'(L_LINES - 1)) ? '0 : wptr_q + 1'b1;
    end
  end

  // The store about to be overwritten holds the oldest line; the others
  // follow it in rotation order up to the most recent line.
  for (genvar k = 0; k < L_LINES; k++) begin : g_rd
    logic [L_PTR_W:0]   sum;
    logic [L_PTR_W-1:0] rd_idx;
    assign sum    = {1'b0, wptr_q} + (L_PTR_W + 1)'(k);
    assign rd_idx = (sum >= (L_PTR_W + 1)'(L_LINES)) ?
                    L_PTR_W'(sum - (L_PTR_W + 1)'(L_LINES)) : L_PTR_W'(sum);
    assign new_col[k] = line_mem[rd_idx][col_eff];
  end
  assign new_col[P_WINDOW-1] = I_PIXEL;

  for (genvar r = 0; r < P_WINDOW; r++) begin : g_row
    for (genvar c = 0; c < P_WINDOW; c++) begin : g_col
      if (c < P_WINDOW - 1) begin : g_old
        assign win_nxt[r][c] = hist_q[r][c];
      end else begin : g_new
        assign win_nxt[r][c] = new_col[r];
      end
      if (c > 0) begin : g_hist
        assign hist_d[r][c-1] = win_nxt[r][c];
      end
`ifdef LINE_WINDOW_BUFFER_ZERO_PAD_EN
      // Tap lies inside the frame when row-(W-1)+r >= 0 and col-(W-1)+c >= 0.
      logic keep;
      assign keep = (({1'b0, row_eff} + (L_ROW_W + 1)'(r)) >= (L_ROW_W + 1)'(P_WINDOW - 1)) &&
                    (({1'b0, col_eff} + (L_COL_W + 1)'(c)) >= (L_COL_W + 1)'(P_WINDOW - 1));
      assign window_flat[(r*P_WINDOW+c)*P_PIXEL_DEPTH +: P_PIXEL_DEPTH] =
        keep ? win_nxt[r][c] : '0;
`else
      assign window_flat[(r*P_WINDOW+c)*P_PIXEL_DEPTH +: P_PIXEL_DEPTH] = win_nxt[r][c];
`endif
    end
  end

  // Position counters and line-write pointer.
  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      col_q  <= '0;
      row_q  <= '0;
      wptr_q <= '0;
    end else if (accept) begin
      col_q  <= col_nxt;
      row_q  <= row_nxt;
      wptr_q <= wptr_nxt;
    end
  end

  // Line-store write of the accepted pixel (read of the same slot happens first).
  always_ff @(posedge I_CLK) begin
    if (accept) begin
      line_mem[wptr_q][col_eff] <= I_PIXEL;
    end
  end

  // Window history shift; every accepted pixel shifts, qualified or not.
  always_ff @(posedge I_CLK) begin
    if (accept) begin
      hist_q <= hist_d;
    end
  end

  // Output register: loads on accept, clears valid once consumed, holds on stall.
  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      O_VALID  <= 1'b0;
      O_WINDOW <= '0;
      O_ROW    <= '0;
      O_COL    <= '0;
      O_EOF    <= 1'b0;
    end else if (accept) begin
      O_VALID  <= qualified;
      O_WINDOW <= window_flat;
      O_ROW    <= row_eff;
      O_COL    <= col_eff;
      O_EOF    <= eof_nxt;
    end else if (I_READY) begin
      O_VALID  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Testbench for line_window_buffer: 8x6 frame, 3x3 window, 8-bit pixels,
// pixel value = row*16 + col + 1. Also builds with
// LINE_WINDOW_BUFFER_ZERO_PAD_EN defined, switching the expected window set.
module tb_line_window_buffer;

  localparam int NCOLS = 8;
  localparam int NROWS = 6;
  localparam int WIN   = 3;
  localparam int DEPTH = 8;

`ifdef LINE_WINDOW_BUFFER_ZERO_PAD_EN
  localparam int N_WIN  = 48;
  localparam int OFF    = 0;
  localparam int NC     = 8;
  localparam int PART_N = 13;
  localparam logic [71:0] FIRST_WIN = 72'h01_00_00_00_00_00_00_00_00;
`else
  localparam int N_WIN  = 24;
  localparam int OFF    = 2;
  localparam int NC     = 6;
  localparam int PART_N = 0;
  localparam logic [71:0] FIRST_WIN = 72'h23_22_21_13_12_11_03_02_01;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i_pixel;
  logic        i_valid;
  logic        i_sof;
  logic        o_ready;
  logic [71:0] o_window;
  logic [2:0]  o_row;
  logic [2:0]  o_col;
  logic        o_eof;
  logic        o_valid;
  logic        i_ready;

  int n_chk   = 0;
  int n_pass  = 0;
  int win_cnt = 0;

  line_window_buffer #(
    .P_COLUMNS(NCOLS), .P_ROWS(NROWS), .P_WINDOW(WIN), .P_PIXEL_DEPTH(DEPTH)
  ) dut (
    .I_CLK(clk), .I_RESET_N(rst_n), .I_PIXEL(i_pixel), .I_VALID(i_valid),
    .I_SOF(i_sof), .O_READY(o_ready), .O_WINDOW(o_window), .O_ROW(o_row),
    .O_COL(o_col), .O_EOF(o_eof), .O_VALID(o_valid), .I_READY(i_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [71:0] exp_window(input int rr, input int cc);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        int pr, pc;
        pr = rr - (WIN - 1) + r;
        pc = cc - (WIN - 1) + c;
        if (pr >= 0 && pc >= 0) w[(r*WIN+c)*8 +: 8] = 8'(pr*16 + pc + 1);
      end
    end
    return w;
  endfunction

  // Scoreboard: every consumed window must be the next one in raster order.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && o_valid && i_ready) begin
        if (win_cnt >= N_WIN) begin
          chk("extra_window", 128'(win_cnt), 128'(N_WIN - 1));
        end else begin
          int er, ec;
          er = OFF + win_cnt / NC;
          ec = OFF + win_cnt % NC;
          chk("win", 128'(o_window), 128'(exp_window(er, ec)));
          chk("row", 128'(o_row), 128'(er));
          chk("col", 128'(o_col), 128'(ec));
          chk("eof", 128'(o_eof), 128'(er == NROWS-1 && ec == NCOLS-1));
          if (win_cnt == 0) chk("first_win", 128'(o_window), 128'(FIRST_WIN));
`ifdef LINE_WINDOW_BUFFER_ZERO_PAD_EN
          if (win_cnt == 8) chk("pad_win_1_0", 128'(o_window), 128'(72'h11_00_00_01_00_00_00_00_00));
`endif
        end
        win_cnt++;
      end
    end
  end

  task automatic send_pixel(input int r, input int c, input logic sof);
    int   waited;
    logic rdy;
    logic done;
    waited  = 0;
    done    = 1'b0;
    i_valid = 1'b1;
    i_pixel = 8'(r*16 + c + 1);
    i_sof   = sof;
    while (!done) begin
      @(negedge clk);
      rdy = o_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
      else begin
        waited++;
        if (waited > 20) begin
          chk("accept_timeout", 128'(0), 128'(1));
          done = 1'b1;
        end
      end
    end
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic stall_5(input int r, input int c, input int nr, input int nc);
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_pixel = 8'(nr*16 + nc + 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_ready", 128'(o_ready), 128'(0));
      chk("stall_valid", 128'(o_valid), 128'(1));
      chk("stall_win", 128'(o_window), 128'(exp_window(r, c)));
      chk("stall_row", 128'(o_row), 128'(r));
      chk("stall_col", 128'(o_col), 128'(c));
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
  endtask

  task automatic drive_pixels(input int npix, input bit gaps, input bit sof, input int stall_at);
    for (int p = 0; p < npix; p++) begin
      if (gaps) begin
        i_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_pixel(p / NCOLS, p % NCOLS, sof && (p == 0));
      if (p == stall_at) stall_5(p / NCOLS, p % NCOLS, (p+1) / NCOLS, (p+1) % NCOLS);
    end
  endtask

  task automatic drain;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b1;
    i_pixel = 8'hAA;
    i_sof   = 1'b0;
    i_ready = 1'b1;

    // Reset held three cycles with valid asserted.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_ready", 128'(o_ready), 128'(0));
      chk("rst_valid", 128'(o_valid), 128'(0));
      chk("rst_window", 128'(o_window), 128'(0));
    end
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 128'(o_ready), 128'(1));
    @(posedge clk);
    #1;

    // Continuous frame.
    win_cnt = 0;
    drive_pixels(48, 1'b0, 1'b1, -1);
    drain();
    chk("count_continuous", 128'(win_cnt), 128'(N_WIN));

    // Backpressure mid-frame at (3,6).
    win_cnt = 0;
    drive_pixels(48, 1'b0, 1'b1, 30);
    drain();
    chk("count_backpressure", 128'(win_cnt), 128'(N_WIN));

    // Input gaps every other cycle.
    win_cnt = 0;
    drive_pixels(48, 1'b1, 1'b1, -1);
    drain();
    chk("count_gaps", 128'(win_cnt), 128'(N_WIN));

    // Partial frame of 13 pixels, then SOF restart.
    win_cnt = 0;
    drive_pixels(13, 1'b0, 1'b1, -1);
    drain();
    chk("count_partial_sof", 128'(win_cnt), 128'(PART_N));
    win_cnt = 0;
    drive_pixels(48, 1'b0, 1'b1, -1);
    drain();
    chk("count_sof_restart", 128'(win_cnt), 128'(N_WIN));

    // Partial frame of 13 pixels, then reset pulse and restart without SOF.
    win_cnt = 0;
    drive_pixels(13, 1'b0, 1'b1, -1);
    drain();
    chk("count_partial_rst", 128'(win_cnt), 128'(PART_N));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_valid", 128'(o_valid), 128'(0));
    rst_n = 1'b1;
    win_cnt = 0;
    drive_pixels(48, 1'b0, 1'b0, -1);
    drain();
    chk("count_rst_restart", 128'(win_cnt), 128'(N_WIN));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
